// File: rtl/ntt_radix_gentleman_sande_pkg.sv
// Shared helpers for the Gentleman-Sande (DIF) butterfly: pipeline latency and Barrett constant.
package ntt_radix_gentleman_sande_pkg;

   // Widest modulus the elaboration-time Barrett constant can handle.
   localparam int unsigned MAX_W = 128;

   // Total cycles from in_avail to out_avail:
   // in pipe + add/sub + multiplier + three reduction stages + out pipe.
   function automatic int unsigned get_latency(input int unsigned mult_lat);
      return 1 + 1 + mult_lat + 3 + 1;
   endfunction

   // floor(2^(2*mod_w) / mod_q) by restoring long division; only evaluated at elaboration.
   function automatic logic [2*MAX_W:0] get_barrett_mu(input int unsigned mod_w,
                                                       input logic [MAX_W-1:0] mod_q);
      logic [MAX_W:0]   rem;
      logic [2*MAX_W:0] quo;
      rem = '0;
      quo = '0;
      for (int i = 2 * int'(mod_w); i >= 0; i--) begin
         // The dividend is a single 1 at bit 2*mod_w.
         rem = {rem[MAX_W-1:0], (i == 2 * int'(mod_w)) ? 1'b1 : 1'b0};
         if (rem >= {1'b0, mod_q}) begin
            rem          = rem - {1'b0, mod_q};
            quo[9'(i)]   = 1'b1;
         end
      end
      return quo;
   endfunction

endpackage

// File: rtl/ntt_gs_barrett_reduct.sv
// Three-stage Barrett reduction of a 2*MOD_W-bit product, with avail and sideband carried along.
module ntt_gs_barrett_reduct
   import ntt_radix_gentleman_sande_pkg::*;
#(
   parameter int unsigned      MOD_W  = 64,
   parameter logic [MOD_W-1:0] MOD_Q  = 64'hFFFF_FFFF_0000_0001,
   parameter int unsigned      SIDE_W = 72
) (
   input  logic                 clk,
   input  logic                 a_rst_n,
   input  logic                 in_avail,
   input  logic [2*MOD_W-1:0]   in_x,
   input  logic [SIDE_W-1:0]    in_side,
   output logic                 out_avail,
   output logic [MOD_W-1:0]     out_r,
   output logic [SIDE_W-1:0]    out_side
);

   localparam logic [MOD_W:0]   MU = (MOD_W+1)'(get_barrett_mu(MOD_W, MAX_W'(MOD_Q)));
   localparam logic [MOD_W+1:0] QX = {2'b00, MOD_Q};

   logic [MOD_W:0]   x_hi;
   logic [MOD_W:0]   t_q;
   logic [MOD_W+1:0] x_lo_q;
   logic [MOD_W+1:0] r_q;
   logic [MOD_W+1:0] r_fix;
   logic             v1_q, v2_q;
   logic [SIDE_W-1:0] side1_q, side2_q;

   assign x_hi = in_x[2*MOD_W-1:MOD_W-1];

   // Final correction: r < 3q, so at most two subtractions bring it below q.
   always_comb begin
      r_fix = r_q;
      if (r_fix >= QX) r_fix = r_fix - QX;
      if (r_fix >= QX) r_fix = r_fix - QX;
   end

   // Avail chain through the three reduction stages; the only control state.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         v1_q      <= 1'b0;
         v2_q      <= 1'b0;
         out_avail <= 1'b0;
      end else begin
         v1_q      <= in_avail;
         v2_q      <= v1_q;
         out_avail <= v2_q;
      end
   end

   // Data path: quotient estimate, remainder (only low MOD_W+2 bits matter), correction.
   always_ff @(posedge clk) begin
      t_q      <= (MOD_W+1)'(((2*MOD_W+2)'(x_hi) * (2*MOD_W+2)'(MU)) >> (MOD_W + 1));
      x_lo_q   <= in_x[MOD_W+1:0];
      side1_q  <= in_side;
      r_q      <= x_lo_q - (MOD_W+2)'(t_q) * (MOD_W+2)'(MOD_Q);
      side2_q  <= side1_q;
      out_r    <= MOD_W'(r_fix);
      out_side <= side2_q;
   end

endmodule

// File: rtl/ntt_radix_gentleman_sande.sv
// Radix-2 decimation-in-frequency butterfly: out_0 = a+b, out_1 = (a-b)*w, all mod q.
module ntt_radix_gentleman_sande
   import ntt_radix_gentleman_sande_pkg::*;
#(
   parameter int unsigned      MOD_W    = 64,
   parameter logic [MOD_W-1:0] MOD_Q    = 64'hFFFF_FFFF_0000_0001,
   parameter int unsigned      MULT_LAT = 2,
   parameter int unsigned      CTRL_W   = 8
) (
   input  logic              clk,
   input  logic              a_rst_n,
   input  logic              in_avail,
   input  logic [MOD_W-1:0]  in_a,
   input  logic [MOD_W-1:0]  in_b,
   input  logic [MOD_W-1:0]  in_w,
   input  logic [CTRL_W-1:0] in_ctrl,
   output logic              out_avail,
   output logic [MOD_W-1:0]  out_0,
   output logic [MOD_W-1:0]  out_1,
   output logic [CTRL_W-1:0] out_ctrl
);

   localparam int unsigned SIDE_W = MOD_W + CTRL_W;

   logic                               in_v_q;
   logic [MOD_W-1:0]                   a_q, b_q, w_q;
   logic [CTRL_W-1:0]                  c_q;
   logic [MOD_W:0]                     sum;
   logic [MOD_W-1:0]                   s_d, d_d;
   logic [MOD_W-1:0]                   md_q, mw_q;
   // Index 0 is the add/sub stage; index MULT_LAT lines up with the multiplier output.
   logic [MULT_LAT:0]                  mv_q;
   logic [MULT_LAT:0][MOD_W-1:0]       ms_q;
   logic [MULT_LAT:0][CTRL_W-1:0]      mc_q;
   logic [MULT_LAT-1:0][2*MOD_W-1:0]   prod_q;
   logic                               red_v;
   logic [MOD_W-1:0]                   red_r;
   logic [SIDE_W-1:0]                  red_side;

   // Modular add and subtract; both results land in [0, q).
   always_comb begin
      sum = {1'b0, a_q} + {1'b0, b_q};
      s_d = (sum >= {1'b0, MOD_Q}) ? MOD_W'(sum - {1'b0, MOD_Q}) : sum[MOD_W-1:0];
      d_d = (a_q < b_q) ? a_q - b_q + MOD_Q : a_q - b_q;
   end

   // Avail shift chain plus the reset-cleared outputs.
   always_ff @(posedge clk or negedge a_rst_n) begin
      if (!a_rst_n) begin
         in_v_q    <= 1'b0;
         mv_q      <= '0;
         out_avail <= 1'b0;
         out_ctrl  <= '0;
      end else begin
         in_v_q    <= in_avail;
         mv_q      <= {mv_q[MULT_LAT-1:0], in_v_q};
         out_avail <= red_v;
         out_ctrl  <= red_side[CTRL_W-1:0];
      end
   end

   // Input, add/sub and sum/ctrl delay registers; clocked every cycle, no reset.
   always_ff @(posedge clk) begin
      a_q   <= in_a;
      b_q   <= in_b;
      w_q   <= in_w;
      c_q   <= in_ctrl;
      md_q  <= d_d;
      mw_q  <= w_q;
      ms_q  <= {ms_q[MULT_LAT-1:0], s_d};
      mc_q  <= {mc_q[MULT_LAT-1:0], c_q};
      out_0 <= red_side[SIDE_W-1:CTRL_W];
      out_1 <= red_r;
   end

   // Generic pipelined product: one multiply followed by retimable delay stages.
   if (MULT_LAT > 1) begin : g_mult_deep
      always_ff @(posedge clk) begin
         prod_q <= {prod_q[MULT_LAT-2:0], (2*MOD_W)'(md_q) * (2*MOD_W)'(mw_q)};
      end
   end else begin : g_mult_single
      always_ff @(posedge clk) begin
         prod_q <= (2*MOD_W)'(md_q) * (2*MOD_W)'(mw_q);
      end
   end

   ntt_gs_barrett_reduct #(
      .MOD_W  (MOD_W),
      .MOD_Q  (MOD_Q),
      .SIDE_W (SIDE_W)
   ) u_reduct (
      .clk       (clk),
      .a_rst_n   (a_rst_n),
      .in_avail  (mv_q[MULT_LAT]),
      .in_x      (prod_q[MULT_LAT-1]),
      .in_side   ({ms_q[MULT_LAT], mc_q[MULT_LAT]}),
      .out_avail (red_v),
      .out_r     (red_r),
      .out_side  (red_side)
   );

endmodule

// File: tb/tb_ntt_radix_gentleman_sande.sv
// Bench for the DIF butterfly: three instances (MULT_LAT 2, 1, 4) share one stimulus stream.
module tb_ntt_radix_gentleman_sande;
   import ntt_radix_gentleman_sande_pkg::*;

   localparam logic [63:0] Q  = 64'hFFFF_FFFF_0000_0001;
   localparam int          HN = 1024;
   localparam int          LAT2 = int'(get_latency(2));
   localparam int          LAT1 = int'(get_latency(1));
   localparam int          LAT4 = int'(get_latency(4));

   logic        clk, a_rst_n, in_avail;
   logic [63:0] in_a, in_b, in_w;
   logic [7:0]  in_ctrl;
   logic        v_l2, v_l1, v_l4;
   logic [63:0] o0_l2, o1_l2, o0_l1, o1_l1, o0_l4, o1_l4;
   logic [7:0]  oc_l2, oc_l1, oc_l4;

   int checks = 0;
   int errors = 0;
   int cyc    = 0;
   int fence  = 0;

   // Expected results indexed by the cycle the beat was offered.
   bit          hv  [HN];
   logic [63:0] he0 [HN];
   logic [63:0] he1 [HN];
   logic [7:0]  hc  [HN];

   ntt_radix_gentleman_sande #(.MULT_LAT(2)) u_dut_l2 (
      .clk(clk), .a_rst_n(a_rst_n), .in_avail(in_avail), .in_a(in_a), .in_b(in_b),
      .in_w(in_w), .in_ctrl(in_ctrl), .out_avail(v_l2), .out_0(o0_l2), .out_1(o1_l2),
      .out_ctrl(oc_l2));
   ntt_radix_gentleman_sande #(.MULT_LAT(1)) u_dut_l1 (
      .clk(clk), .a_rst_n(a_rst_n), .in_avail(in_avail), .in_a(in_a), .in_b(in_b),
      .in_w(in_w), .in_ctrl(in_ctrl), .out_avail(v_l1), .out_0(o0_l1), .out_1(o1_l1),
      .out_ctrl(oc_l1));
   ntt_radix_gentleman_sande #(.MULT_LAT(4)) u_dut_l4 (
      .clk(clk), .a_rst_n(a_rst_n), .in_avail(in_avail), .in_a(in_a), .in_b(in_b),
      .in_w(in_w), .in_ctrl(in_ctrl), .out_avail(v_l4), .out_0(o0_l4), .out_1(o1_l4),
      .out_ctrl(oc_l4));

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

   // Reference model: plain modular arithmetic on 128-bit integers.
   function automatic logic [63:0] ref0(input logic [63:0] a, input logic [63:0] b);
      logic [127:0] t;
      t = 128'(a) + 128'(b);
      return 64'(t % 128'(Q));
   endfunction

   function automatic logic [63:0] ref1(input logic [63:0] a, input logic [63:0] b,
                                        input logic [63:0] w);
      logic [127:0] d;
      d = (128'(a) + 128'(Q) - 128'(b)) % 128'(Q);
      return 64'((d * 128'(w)) % 128'(Q));
   endfunction

   function automatic logic [63:0] rnd();
      logic [63:0] v;
      v = {$urandom, $urandom};
      case ($urandom_range(0, 7))
         0: v = 64'd0;
         1: v = Q - 64'd1;
         2: v = 64'd1;
         default: ;
      endcase
      if (v >= Q) v = v - Q;
      return v;
   endfunction

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic chk_out(input string tag, input int lat, input logic v,
                          input logic [63:0] o0, input logic [63:0] o1, input logic [7:0] oc);
      int idx;
      bit ev;
      idx = cyc - lat;
      ev  = 1'b0;
      if (idx >= fence) ev = hv[10'(idx)];
      chk({tag, "_avail"}, 64'(v), 64'(ev));
      if (ev) begin
         chk({tag, "_out0"}, o0, he0[10'(idx)]);
         chk({tag, "_out1"}, o1, he1[10'(idx)]);
         chk({tag, "_ctrl"}, 64'(oc), 64'(hc[10'(idx)]));
      end
   endtask

   // One clock: offer a beat (or bubble), record its expectation, then check all outputs.
   task automatic step(input bit v, input logic [63:0] a, input logic [63:0] b,
                       input logic [63:0] w, input logic [7:0] c);
      in_avail = v;
      in_a     = a;
      in_b     = b;
      in_w     = w;
      in_ctrl  = c;
      hv[10'(cyc)]  = v;
      he0[10'(cyc)] = ref0(a, b);
      he1[10'(cyc)] = ref1(a, b, w);
      hc[10'(cyc)]  = c;
      @(posedge clk);
      #1;
      cyc++;
      chk_out("l2", LAT2, v_l2, o0_l2, o1_l2, oc_l2);
      chk_out("l1", LAT1, v_l1, o0_l1, o1_l1, oc_l1);
      chk_out("l4", LAT4, v_l4, o0_l4, o1_l4, oc_l4);
   endtask

   // Single beat into an empty pipeline; measure each instance's latency and check values.
   task automatic directed(input string tag, input logic [63:0] a, input logic [63:0] b,
                           input logic [63:0] w, input logic [7:0] c,
                           input logic [63:0] e0, input logic [63:0] e1);
      int f2, f1, f4;
      logic [63:0] g0, g1;
      logic [7:0]  gc;
      f2 = 0; f1 = 0; f4 = 0;
      g0 = 'x; g1 = 'x; gc = 'x;
      step(1'b1, a, b, w, c);
      for (int k = 1; k <= 12; k++) begin
         if (v_l2 && f2 == 0) begin
            f2 = k;
            g0 = o0_l2;
            g1 = o1_l2;
            gc = oc_l2;
         end
         if (v_l1 && f1 == 0) f1 = k;
         if (v_l4 && f4 == 0) f4 = k;
         step(1'b0, 64'd0, 64'd0, 64'd0, 8'd0);
      end
      chk({tag, "_lat_l2"}, 64'(f2), 64'd8);
      chk({tag, "_lat_l1"}, 64'(f1), 64'd7);
      chk({tag, "_lat_l4"}, 64'(f4), 64'd10);
      chk({tag, "_getlat_l1"}, 64'(f1), 64'(get_latency(1)));
      chk({tag, "_getlat_l4"}, 64'(f4), 64'(get_latency(4)));
      chk({tag, "_out0"}, g0, e0);
      chk({tag, "_out1"}, g1, e1);
      chk({tag, "_ctrl"}, 64'(gc), 64'(c));
   endtask

   initial begin
      logic [63:0] ra, rb, rw;
      a_rst_n  = 1'b0;
      in_avail = 1'b0;
      in_a     = '0;
      in_b     = '0;
      in_w     = '0;
      in_ctrl  = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_avail_l2", 64'(v_l2), 64'd0);
      chk("rst_avail_l1", 64'(v_l1), 64'd0);
      chk("rst_avail_l4", 64'(v_l4), 64'd0);
      chk("rst_ctrl_l2", 64'(oc_l2), 64'd0);
      a_rst_n = 1'b1;

      // First beat goes in on the very first edge after release.
      directed("basic", 64'd5, 64'd3, 64'd2, 8'h11, 64'd8, 64'd4);
      directed("wrap_sub", 64'd3, 64'd5, 64'd1, 8'h22, 64'd8, Q - 64'd2);
      directed("wrap_add", Q - 64'd1, 64'd1, 64'd1, 8'h33, 64'd0, Q - 64'd2);
      directed("big_prod", Q - 64'd1, 64'd0, Q - 64'd1, 8'h44, Q - 64'd1, 64'd1);

      for (int i = 0; i < 100; i++) step(1'b1, rnd(), rnd(), rnd(), 8'($urandom));
      for (int i = 0; i < 40; i++) step((i % 2) == 0, rnd(), rnd(), rnd(), 8'($urandom));
      repeat (12) step(1'b0, 64'd0, 64'd0, 64'd0, 8'd0);

      // Reset with five beats in flight: they must vanish.
      for (int i = 0; i < 5; i++) step(1'b1, rnd(), rnd(), rnd(), 8'($urandom));
      a_rst_n = 1'b0;
      #1;
      chk("midrst_avail_l2", 64'(v_l2), 64'd0);
      chk("midrst_avail_l1", 64'(v_l1), 64'd0);
      chk("midrst_avail_l4", 64'(v_l4), 64'd0);
      chk("midrst_ctrl_l2", 64'(oc_l2), 64'd0);
      fence = cyc;
      step(1'b0, 64'd0, 64'd0, 64'd0, 8'd0);
      a_rst_n = 1'b1;
      repeat (10) step(1'b0, 64'd0, 64'd0, 64'd0, 8'd0);
      ra = rnd();
      rb = rnd();
      rw = rnd();
      directed("post_rst", ra, rb, rw, 8'h5a, ref0(ra, rb), ref1(ra, rb, rw));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
